// File: rtl/commit_pkg.sv
// rtl/commit_pkg.sv - shared widths, state encoding and retire-kind decode for the commit unit
package commit_pkg;

  localparam int TAG_W  = 5;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    STORE_WAIT,
    FLUSH
  } state_e;

  typedef enum logic [1:0] {
    ALU,
    BRANCH,
    STORE
  } retire_kind_e;

  // A branch never carries a store, so the branch flag takes precedence.
  function automatic retire_kind_e classify(input logic branch, input logic store_ready);
    if (branch) return BRANCH;
    else if (store_ready) return STORE;
    else return ALU;
  endfunction

endpackage

// File: rtl/commit_arch_regfile.sv
// rtl/commit_arch_regfile.sv - architectural register file, one write and one combinational read port, r0 reads zero
module arch_regfile
  import commit_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0 && int'(waddr) < NREGS) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = (raddr == '0 || int'(raddr) >= NREGS) ? '0 : regs[raddr];

endmodule

// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - retire/commit stage: register writeback, store release, branch flush; optional COMMIT_BYPASS_EN read bypass
module commit_unit
  import commit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int NREGS        = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              retire_valid,
  input  logic [TAG_W-1:0]  retire_rd_tag,
  input  logic [REG_W-1:0]  retire_rd_reg,
  input  logic [DATA_W-1:0] retire_data,
  input  logic [31:0]       retire_pc,
  input  logic              retire_branch,
  input  logic              retire_branch_taken,
  input  logic              retire_store_ready,
  output logic              retire_stall,
  input  logic [REG_W-1:0]  rf_rd_addr,
  output logic [DATA_W-1:0] rf_rd_data,
  output logic              tag_free,
  output logic [TAG_W-1:0]  tag_free_id,
  output logic              store_commit,
  input  logic              store_commit_ack,
  output logic              flush,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic [31:0]       commit_count
);

  localparam int CNT_W = 4;

  state_e           state, state_next;
  retire_kind_e     kind;
  logic [CNT_W-1:0] flush_cnt;
  logic [TAG_W-1:0] store_tag;
  logic [TAG_W-1:0] commit_tag;
  logic             accept;
  logic             rf_we;
  logic             commit_now;
  logic [DATA_W-1:0] rf_q;

  assign kind   = classify(retire_branch, retire_store_ready);
  assign accept = (state == IDLE) && retire_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    retire_stall = 1'b0;
    store_commit = 1'b0;
    flush        = 1'b0;
    rf_we        = 1'b0;
    commit_now   = 1'b0;
    commit_tag   = retire_rd_tag;
    case (state)
      IDLE: begin
        if (retire_valid) begin
          case (kind)
            ALU: begin
              rf_we      = 1'b1;
              commit_now = 1'b1;
            end
            BRANCH: begin
              commit_now = 1'b1;
              if (retire_branch_taken) state_next = FLUSH;
            end
            STORE:   state_next = STORE_WAIT;
            default: state_next = IDLE;
          endcase
        end
      end
      STORE_WAIT: begin
        retire_stall = 1'b1;
        store_commit = 1'b1;
        commit_tag   = store_tag;
        if (store_commit_ack) begin
          commit_now = 1'b1;
          state_next = IDLE;
        end
      end
      FLUSH: begin
        retire_stall = 1'b1;
        flush        = 1'b1;
        if (flush_cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stores free their tag only once the store buffer has taken them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_free       <= 1'b0;
      tag_free_id    <= '0;
      commit_count   <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_cnt      <= '0;
      store_tag      <= '0;
    end else begin
      tag_free       <= commit_now;
      redirect_valid <= 1'b0;
      if (commit_now) begin
        tag_free_id  <= commit_tag;
        commit_count <= commit_count + 32'd1;
      end
      if (accept) store_tag <= retire_rd_tag;
      if (accept && kind == BRANCH) begin
        flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
        if (retire_branch_taken) begin
          redirect_valid <= 1'b1;
          redirect_pc    <= retire_pc;
        end
      end else if (state == FLUSH && flush_cnt != '0) begin
        flush_cnt <= flush_cnt - CNT_W'(1);
      end
    end
  end

  arch_regfile #(
    .NREGS(NREGS)
  ) u_regfile (
    .clock (clock),
    .reset (reset),
    .we    (rf_we),
    .waddr (retire_rd_reg),
    .wdata (retire_data),
    .raddr (rf_rd_addr),
    .rdata (rf_q)
  );

`ifdef COMMIT_BYPASS_EN
  assign rf_rd_data = (rf_we && retire_rd_reg != '0 && rf_rd_addr == retire_rd_reg) ? retire_data : rf_q;
`else
  assign rf_rd_data = rf_q;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// tb/tb_commit_unit.sv - self-checking bench for commit_unit with a transaction-level reference model
module tb_commit_unit;

  localparam int FC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        retire_valid = 1'b0;
  logic [4:0]  retire_rd_tag = '0;
  logic [4:0]  retire_rd_reg = '0;
  logic [31:0] retire_data = '0;
  logic [31:0] retire_pc = '0;
  logic        retire_branch = 1'b0;
  logic        retire_branch_taken = 1'b0;
  logic        retire_store_ready = 1'b0;
  logic        retire_stall;
  logic [4:0]  rf_rd_addr = '0;
  logic [31:0] rf_rd_data;
  logic        tag_free;
  logic [4:0]  tag_free_id;
  logic        store_commit;
  logic        store_commit_ack = 1'b0;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] commit_count;

  int          total = 0;
  int          passed = 0;
  logic [31:0] model_rf [32];
  logic [31:0] exp_count = '0;

  commit_unit #(.FLUSH_CYCLES(FC), .NREGS(32)) dut (
    .clock(clock), .reset(reset),
    .retire_valid(retire_valid), .retire_rd_tag(retire_rd_tag), .retire_rd_reg(retire_rd_reg),
    .retire_data(retire_data), .retire_pc(retire_pc), .retire_branch(retire_branch),
    .retire_branch_taken(retire_branch_taken), .retire_store_ready(retire_store_ready),
    .retire_stall(retire_stall), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .tag_free(tag_free), .tag_free_id(tag_free_id), .store_commit(store_commit),
    .store_commit_ack(store_commit_ack), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .commit_count(commit_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    retire_valid = 1'b0; retire_branch = 1'b0; retire_branch_taken = 1'b0;
    retire_store_ready = 1'b0; store_commit_ack = 1'b0;
  endtask

  task automatic present(input int kind, input logic [4:0] tag, input logic [4:0] rd,
                         input logic [31:0] data, input logic [31:0] pc);
    retire_valid = 1'b1; retire_rd_tag = tag; retire_rd_reg = rd; retire_data = data; retire_pc = pc;
    retire_store_ready = (kind == 1); retire_branch = (kind >= 2); retire_branch_taken = (kind == 2);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    exp_count = '0;
    total++; if (retire_stall !== 1'b0) $display("FAIL reset_stall got %h want 0", retire_stall); else passed++;
    total++; if (flush !== 1'b0) $display("FAIL reset_flush got %h want 0", flush); else passed++;
    total++; if (redirect_valid !== 1'b0) $display("FAIL reset_redirect got %h want 0", redirect_valid); else passed++;
    total++; if (redirect_pc !== 32'h0) $display("FAIL reset_redirect_pc got %h want 0", redirect_pc); else passed++;
    total++; if (tag_free !== 1'b0) $display("FAIL reset_tag_free got %h want 0", tag_free); else passed++;
    total++; if (store_commit !== 1'b0) $display("FAIL reset_store_commit got %h want 0", store_commit); else passed++;
    total++; if (commit_count !== 32'h0) $display("FAIL reset_count got %h want 0", commit_count); else passed++;
    for (int r = 0; r < 32; r += 7) begin
      rf_rd_addr = 5'(r); #1;
      total++; if (rf_rd_data !== 32'h0) $display("FAIL reset_rf r%0d got %h want 0", r, rf_rd_data); else passed++;
    end
  endtask

  task automatic test_alu();
    present(0, 5'd3, 5'd5, 32'hDEADBEEF, 32'h0);
    tick(); idle_inputs();
    model_rf[5] = 32'hDEADBEEF; exp_count++;
    total++; if (tag_free !== 1'b1) $display("FAIL alu_tag_free got %h want 1", tag_free); else passed++;
    total++; if (tag_free_id !== 5'd3) $display("FAIL alu_tag_id got %h want 3", tag_free_id); else passed++;
    total++; if (commit_count !== exp_count) $display("FAIL alu_count got %h want %h", commit_count, exp_count); else passed++;
    rf_rd_addr = 5'd5; #1;
    total++; if (rf_rd_data !== model_rf[5]) $display("FAIL alu_rf5 got %h want %h", rf_rd_data, model_rf[5]); else passed++;
    tick();
    total++; if (tag_free !== 1'b0) $display("FAIL alu_tag_free_pulse got %h want 0", tag_free); else passed++;
  endtask

  task automatic test_reg0();
    present(0, 5'd11, 5'd0, 32'h00001234, 32'h0);
    tick(); idle_inputs(); exp_count++;
    total++; if (tag_free !== 1'b1) $display("FAIL r0_tag_free got %h want 1", tag_free); else passed++;
    total++; if (tag_free_id !== 5'd11) $display("FAIL r0_tag_id got %h want 11", tag_free_id); else passed++;
    rf_rd_addr = 5'd0; #1;
    total++; if (rf_rd_data !== 32'h0) $display("FAIL r0_read got %h want 0", rf_rd_data); else passed++;
  endtask

  task automatic test_store();
    store_commit_ack = 1'b1; tick(); store_commit_ack = 1'b0;
    total++; if (tag_free !== 1'b0) $display("FAIL stray_ack_tag_free got %h want 0", tag_free); else passed++;
    present(1, 5'd7, 5'd4, 32'hCAFEF00D, 32'h0);
    tick(); idle_inputs();
    for (int c = 1; c <= 3; c++) begin
      total++; if (store_commit !== 1'b1) $display("FAIL st_commit c%0d got %h want 1", c, store_commit); else passed++;
      total++; if (retire_stall !== 1'b1) $display("FAIL st_stall c%0d got %h want 1", c, retire_stall); else passed++;
      total++; if (tag_free !== 1'b0) $display("FAIL st_early_free c%0d got %h want 0", c, tag_free); else passed++;
      if (c == 2) present(0, 5'd9, 5'd6, 32'hBAD0BAD0, 32'h0);
      if (c == 3) store_commit_ack = 1'b1;
      tick(); idle_inputs();
    end
    exp_count++;
    total++; if (store_commit !== 1'b0) $display("FAIL st_commit_end got %h want 0", store_commit); else passed++;
    total++; if (tag_free !== 1'b1) $display("FAIL st_tag_free got %h want 1", tag_free); else passed++;
    total++; if (tag_free_id !== 5'd7) $display("FAIL st_tag_id got %h want 7", tag_free_id); else passed++;
    total++; if (commit_count !== exp_count) $display("FAIL st_count got %h want %h", commit_count, exp_count); else passed++;
    rf_rd_addr = 5'd4; #1;
    total++; if (rf_rd_data !== model_rf[4]) $display("FAIL st_no_write got %h want %h", rf_rd_data, model_rf[4]); else passed++;
    rf_rd_addr = 5'd6; #1;
    total++; if (rf_rd_data !== model_rf[6]) $display("FAIL st_ignored_retire got %h want %h", rf_rd_data, model_rf[6]); else passed++;
    tick();
    total++; if (tag_free !== 1'b0) $display("FAIL st_extra_free got %h want 0", tag_free); else passed++;
    total++; if (commit_count !== exp_count) $display("FAIL st_extra_count got %h want %h", commit_count, exp_count); else passed++;
  endtask

  task automatic test_store_fast_ack();
    present(1, 5'd21, 5'd2, 32'h0, 32'h0);
    tick(); idle_inputs();
    total++; if (store_commit !== 1'b1) $display("FAIL fast_commit got %h want 1", store_commit); else passed++;
    store_commit_ack = 1'b1;
    tick(); idle_inputs(); exp_count++;
    total++; if (store_commit !== 1'b0) $display("FAIL fast_commit_end got %h want 0", store_commit); else passed++;
    total++; if (tag_free_id !== 5'd21 || tag_free !== 1'b1) $display("FAIL fast_free got %b/%h want 1/15", tag_free, tag_free_id); else passed++;
  endtask

  task automatic test_branch();
    present(2, 5'd12, 5'd8, 32'h77777777, 32'h00400100);
    tick(); idle_inputs(); exp_count++;
    total++; if (redirect_valid !== 1'b1) $display("FAIL br_redirect got %h want 1", redirect_valid); else passed++;
    total++; if (redirect_pc !== 32'h00400100) $display("FAIL br_pc got %h want 00400100", redirect_pc); else passed++;
    total++; if (tag_free_id !== 5'd12 || tag_free !== 1'b1) $display("FAIL br_free got %b/%h want 1/0c", tag_free, tag_free_id); else passed++;
    for (int c = 0; c < FC; c++) begin
      total++; if (flush !== 1'b1) $display("FAIL br_flush c%0d got %h want 1", c, flush); else passed++;
      total++; if (retire_stall !== 1'b1) $display("FAIL br_stall c%0d got %h want 1", c, retire_stall); else passed++;
      if (c > 0) begin
        total++; if (redirect_valid !== 1'b0) $display("FAIL br_redirect_pulse c%0d got %h want 0", c, redirect_valid); else passed++;
      end
      tick();
    end
    total++; if (flush !== 1'b0) $display("FAIL br_flush_end got %h want 0", flush); else passed++;
    total++; if (retire_stall !== 1'b0) $display("FAIL br_stall_end got %h want 0", retire_stall); else passed++;
    rf_rd_addr = 5'd8; #1;
    total++; if (rf_rd_data !== model_rf[8]) $display("FAIL br_no_write got %h want %h", rf_rd_data, model_rf[8]); else passed++;
  endtask

  task automatic test_branch_not_taken();
    present(3, 5'd13, 5'd8, 32'h88888888, 32'h00400200);
    tick(); idle_inputs(); exp_count++;
    total++; if (flush !== 1'b0 || redirect_valid !== 1'b0) $display("FAIL bnt_flush got %b%b want 00", flush, redirect_valid); else passed++;
    total++; if (retire_stall !== 1'b0) $display("FAIL bnt_stall got %h want 0", retire_stall); else passed++;
    total++; if (tag_free_id !== 5'd13 || tag_free !== 1'b1) $display("FAIL bnt_free got %b/%h want 1/0d", tag_free, tag_free_id); else passed++;
    rf_rd_addr = 5'd8; #1;
    total++; if (rf_rd_data !== model_rf[8]) $display("FAIL bnt_no_write got %h want %h", rf_rd_data, model_rf[8]); else passed++;
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    present(0, 5'd1, 5'd9, 32'h11111111, 32'h0);
    tick(); idle_inputs(); model_rf[9] = 32'h11111111; exp_count++;
    rf_rd_addr = 5'd9;
    present(0, 5'd2, 5'd9, 32'hA5A5A5A5, 32'h0);
    #1;
`ifdef COMMIT_BYPASS_EN
    want = 32'hA5A5A5A5;
`else
    want = model_rf[9];
`endif
    total++; if (rf_rd_data !== want) $display("FAIL bypass_same_cycle got %h want %h", rf_rd_data, want); else passed++;
    tick(); idle_inputs(); model_rf[9] = 32'hA5A5A5A5; exp_count++;
    total++; if (rf_rd_data !== model_rf[9]) $display("FAIL bypass_after got %h want %h", rf_rd_data, model_rf[9]); else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      int          k;
      int          kind;
      logic [4:0]  tag, rd, ra;
      logic [31:0] data, pc;
      k = $urandom_range(0, 5);
      kind = (k > 3) ? 0 : k;
      tag = 5'($urandom); rd = 5'($urandom); data = $urandom; pc = $urandom;
      present(kind, tag, rd, data, pc);
      tick(); idle_inputs();
      if (kind == 1) begin
        int w;
        w = $urandom_range(1, 4);
        for (int c = 1; c <= w; c++) begin
          total++; if (store_commit !== 1'b1 || retire_stall !== 1'b1) $display("FAIL rnd_store_wait n%0d got %b%b want 11", n, store_commit, retire_stall); else passed++;
          if (c == w) store_commit_ack = 1'b1;
          else if ($urandom_range(0, 1) == 1) present(0, 5'($urandom), 5'($urandom), $urandom, 32'h0);
          tick(); idle_inputs();
        end
        total++; if (store_commit !== 1'b0) $display("FAIL rnd_store_end n%0d got %h want 0", n, store_commit); else passed++;
      end
      if (kind == 0 && rd != 5'd0) model_rf[rd] = data;
      exp_count++;
      total++; if (tag_free !== 1'b1 || tag_free_id !== tag) $display("FAIL rnd_free n%0d got %b/%h want 1/%h", n, tag_free, tag_free_id, tag); else passed++;
      total++; if (commit_count !== exp_count) $display("FAIL rnd_count n%0d got %h want %h", n, commit_count, exp_count); else passed++;
      if (kind == 2) begin
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== pc) $display("FAIL rnd_redirect n%0d got %b/%h want 1/%h", n, redirect_valid, redirect_pc, pc); else passed++;
        for (int c = 0; c < FC; c++) begin
          total++; if (flush !== 1'b1) $display("FAIL rnd_flush n%0d c%0d got %h want 1", n, c, flush); else passed++;
          tick();
        end
        total++; if (flush !== 1'b0) $display("FAIL rnd_flush_end n%0d got %h want 0", n, flush); else passed++;
      end else begin
        total++; if (flush !== 1'b0 || redirect_valid !== 1'b0) $display("FAIL rnd_no_flush n%0d got %b%b want 00", n, flush, redirect_valid); else passed++;
      end
      ra = (kind == 0 && $urandom_range(0, 1) == 1) ? rd : 5'($urandom);
      rf_rd_addr = ra; #1;
      total++; if (rf_rd_data !== model_rf[ra]) $display("FAIL rnd_rf n%0d r%0d got %h want %h", n, ra, rf_rd_data, model_rf[ra]); else passed++;
      if ($urandom_range(0, 3) == 0) begin
        tick();
        total++; if (tag_free !== 1'b0) $display("FAIL rnd_idle_free n%0d got %h want 0", n, tag_free); else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_op();
    present(2, 5'd5, 5'd3, 32'h0, 32'h12345678);
    tick(); idle_inputs();
    reset = 1'b1; #1;
    total++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || retire_stall !== 1'b0) $display("FAIL rst_flush_outs got %b%b%b want 000", flush, redirect_valid, retire_stall); else passed++;
    total++; if (tag_free !== 1'b0 || redirect_pc !== 32'h0) $display("FAIL rst_flush_free got %b/%h want 0/0", tag_free, redirect_pc); else passed++;
    total++; if (commit_count !== 32'h0) $display("FAIL rst_flush_count got %h want 0", commit_count); else passed++;
    tick(); reset = 1'b0;
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    exp_count = '0;
    present(0, 5'd1, 5'd10, 32'h5555AAAA, 32'h0);
    tick(); idle_inputs(); model_rf[10] = 32'h5555AAAA;
    present(1, 5'd6, 5'd0, 32'h0, 32'h0);
    tick(); idle_inputs();
    reset = 1'b1; #1;
    total++; if (store_commit !== 1'b0 || retire_stall !== 1'b0 || tag_free !== 1'b0) $display("FAIL rst_store_outs got %b%b%b want 000", store_commit, retire_stall, tag_free); else passed++;
    total++; if (commit_count !== 32'h0) $display("FAIL rst_store_count got %h want 0", commit_count); else passed++;
    model_rf[10] = '0;
    store_commit_ack = 1'b1;
    tick(); reset = 1'b0;
    tick(); idle_inputs();
    total++; if (tag_free !== 1'b0 || commit_count !== 32'h0) $display("FAIL rst_store_abandon got %b/%h want 0/0", tag_free, commit_count); else passed++;
    rf_rd_addr = 5'd10; #1;
    total++; if (rf_rd_data !== model_rf[10]) $display("FAIL rst_rf_cleared got %h want %h", rf_rd_data, model_rf[10]); else passed++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_reg0();
    test_store();
    test_store_fast_ack();
    test_branch();
    test_branch_not_taken();
    test_bypass();
    test_random();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
